// File: rtl/ir_sched.sv
// IR emitter strobe scheduler, receiver debouncer and center-line counter for the Knight drive path.
// Optional macro IR_TIMEOUT_EN adds a no-crossing strobe timeout that raises move_err.
module ir_sched #(
    parameter int EN_PERIOD       = 2048,
    parameter int EN_ON           = 256,
    parameter int DEB             = 2,
    parameter int TIMEOUT_STROBES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] num_sq,
    input  logic       abort,
    input  logic       lftIR_n,
    input  logic       cntrIR_n,
    input  logic       rghtIR_n,
    output logic       IR_en,
    output logic       busy,
    output logic       lft_rail,
    output logic       rght_rail,
    output logic [3:0] line_cnt,
    output logic       move_done,
    output logic       move_err
);
    localparam int PCW = $clog2(EN_PERIOD);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q;
    logic [PCW-1:0] pc_q, pc_d;
    logic [2:0]     sync1_q, sync2_q, present;
    logic [2:0]     deb_q, deb_d;
    logic [2:0]     agree_q [3];
    logic [2:0]     agree_d [3];
    logic [3:0]     target_q, line_q, lineInc;
    logic           irEn_q, done_q;
    logic           strobe, crossing, finish, timeout;

    // Channel order in all 3-bit vectors: [0] left, [1] center, [2] right.
    assign present  = ~sync2_q;
    assign strobe   = (state_q == RUN) && (pc_q == PCW'(EN_ON - 1));
    assign pc_d     = (pc_q == PCW'(EN_PERIOD - 1)) ? '0 : pc_q + 1'b1;
    assign crossing = strobe && !deb_q[1] && deb_d[1];
    assign lineInc  = (line_q == 4'd15) ? 4'd15 : line_q + 4'd1;
    assign finish   = crossing && (lineInc == target_q);

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            agree_d[i] = agree_q[i];
        end
        if (strobe) begin
            for (int i = 0; i < 3; i++) begin
                if (present[i] == deb_q[i]) begin
                    agree_d[i] = '0;
                end else if (agree_q[i] == 3'(DEB - 1)) begin
                    deb_d[i]   = ~deb_q[i];
                    agree_d[i] = '0;
                end else begin
                    agree_d[i] = agree_q[i] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= {rghtIR_n, cntrIR_n, lftIR_n};
            sync2_q <= sync1_q;
        end
    end

    // Any exit from RUN scrubs the strobe phase and debounce history; line count is kept for readback.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            irEn_q   <= 1'b0;
            deb_q    <= '0;
            agree_q  <= '{default: '0};
            target_q <= '0;
            line_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_sq != 3'd0) begin
                            state_q  <= RUN;
                            target_q <= {num_sq, 1'b0};
                            line_q   <= '0;
                            pc_q     <= '0;
                            irEn_q   <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (crossing) begin
                        line_q <= lineInc;
                    end
                    if (abort || finish || timeout) begin
                        state_q <= IDLE;
                        pc_q    <= '0;
                        irEn_q  <= 1'b0;
                        deb_q   <= '0;
                        agree_q <= '{default: '0};
                        done_q  <= finish && !abort;
                    end else begin
                        pc_q    <= pc_d;
                        irEn_q  <= (pc_d < PCW'(EN_ON));
                        deb_q   <= deb_d;
                        agree_q <= agree_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_STROBES + 1);

    logic [TW-1:0] strobeCnt_q;
    logic          err_q;

    assign timeout = strobe && !crossing && (strobeCnt_q == TW'(TIMEOUT_STROBES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            strobeCnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= timeout && !abort;
            if ((state_q != RUN) || crossing || timeout || abort) begin
                strobeCnt_q <= '0;
            end else if (strobe) begin
                strobeCnt_q <= strobeCnt_q + 1'b1;
            end
        end
    end

    assign move_err = err_q;
`else
    assign timeout  = 1'b0;
    assign move_err = 1'b0;
`endif

    assign IR_en     = irEn_q;
    assign busy      = (state_q == RUN);
    assign lft_rail  = deb_q[0];
    assign rght_rail = deb_q[2];
    assign line_cnt  = line_q;
    assign move_done = done_q;

endmodule

// File: tb/tb_ir_sched.sv
// Scoreboard bench for ir_sched: stimulus queues expected line/done/err events, a monitor checks them.
// Uses a shortened strobe period so several full moves fit in a short run.
`timescale 1ns/1ps
module tb_ir_sched;
    localparam int P    = 32;
    localparam int ON   = 4;
    localparam int DEBN = 2;
    localparam int TMO  = 8;

    localparam int LINE = 0;
    localparam int DONE = 1;
    localparam int ERR  = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] num_sq = 3'd0;
    logic       abort = 1'b0;
    logic       lftIR_n = 1'b1;
    logic       cntrIR_n = 1'b1;
    logic       rghtIR_n = 1'b1;
    logic       IR_en, busy, lft_rail, rght_rail, move_done, move_err;
    logic [3:0] line_cnt;

    ev_t  expQ[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   nextStrobe = 0;
    int   expLine = 0;
    logic monOn = 1'b0;
    logic [3:0] prevLine = 4'd0;

    ir_sched #(
        .EN_PERIOD(P),
        .EN_ON(ON),
        .DEB(DEBN),
        .TIMEOUT_STROBES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_sq(num_sq),
        .abort(abort),
        .lftIR_n(lftIR_n),
        .cntrIR_n(cntrIR_n),
        .rghtIR_n(rghtIR_n),
        .IR_en(IR_en),
        .busy(busy),
        .lft_rail(lft_rail),
        .rght_rail(rght_rail),
        .line_cnt(line_cnt),
        .move_done(move_done),
        .move_err(move_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pushExp(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        expQ.push_back(e);
    endtask

    task automatic checkEvent(input int kind, input int val);
        ev_t e;
        tests++;
        if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected event: got kind %0d val %0d at cycle %0d, expected none", kind, val, cyc);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                fails++;
                $display("[TB] FAIL event: got kind %0d val %0d cycle %0d, expected kind %0d val %0d cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every line_cnt change, move_done pulse and move_err pulse is matched against the queue.
    always @(negedge clk) begin
        if (monOn) begin
            if (line_cnt != prevLine) checkEvent(LINE, int'(line_cnt));
            if (move_done) checkEvent(DONE, int'(line_cnt));
            if (move_err) checkEvent(ERR, int'(line_cnt));
        end
        prevLine <= line_cnt;
    end

    task automatic applyStimulus(input logic st, input logic [2:0] n, input logic ab);
        start  = st;
        num_sq = n;
        abort  = ab;
    endtask

    // Issues a start pulse; returns at the negedge following the edge that took it.
    task automatic startMove(input logic [2:0] n);
        @(negedge clk);
        applyStimulus(1'b1, n, 1'b0);
        if (n != 3'd0) begin
            if (expLine != 0) pushExp(LINE, 0, cyc + 1);
            expLine = 0;
        end else begin
            pushExp(DONE, expLine, cyc + 1);
        end
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 1'b0);
        nextStrobe = cyc + ON;
    endtask

    task automatic toStrobe();
        while (cyc < nextStrobe) @(negedge clk);
        nextStrobe += P;
    endtask

    task automatic crossAtNext(input logic isLast);
        expLine++;
        pushExp(LINE, expLine, nextStrobe);
        if (isLast) pushExp(DONE, expLine, nextStrobe);
    endtask

    initial begin
        int irHigh;
        int anyOut;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        monOn = 1'b1;
        checkOutput("reset IR_en", int'(IR_en), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset line_cnt", int'(line_cnt), 0);
        checkOutput("reset rails", int'({lft_rail, rght_rail}), 0);
        checkOutput("reset pulses", int'({move_done, move_err}), 0);

        irHigh = 0;
        anyOut = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (IR_en) irHigh++;
            if (busy || lft_rail || rght_rail || move_done || move_err || line_cnt != 4'd0) anyOut++;
        end
        checkOutput("idle IR_en cycles", irHigh, 0);
        checkOutput("idle active outputs", anyOut, 0);

        // One square: two center crossings, the second completes the move.
        startMove(3'd1);
        checkOutput("IR_en right after start", int'(IR_en), 1);
        checkOutput("busy right after start", int'(busy), 1);
        for (int k = 0; k < 10; k++) begin
            cntrIR_n = (k < 3 || k >= 8) ? 1'b0 : 1'b1;
            if (k == 1) crossAtNext(1'b0);
            if (k == 9) crossAtNext(1'b1);
            toStrobe();
            if (k == 1) begin
                checkOutput("busy mid move", int'(busy), 1);
                checkOutput("IR_en off after strobe", int'(IR_en), 0);
            end
        end
        checkOutput("busy at done", int'(busy), 0);
        checkOutput("IR_en at done", int'(IR_en), 0);
        cntrIR_n = 1'b1;

        // Short glitch must be filtered; a two-strobe left detect sets the rail.
        startMove(3'd1);
        for (int k = 0; k < 3; k++) begin
            cntrIR_n = (k == 0) ? 1'b0 : 1'b1;
            lftIR_n  = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            toStrobe();
            if (k == 1) checkOutput("lft_rail after 1 strobe", int'(lft_rail), 0);
        end
        checkOutput("lft_rail after 2 strobes", int'(lft_rail), 1);
        checkOutput("rght_rail stays low", int'(rght_rail), 0);
        checkOutput("glitch line_cnt", int'(line_cnt), 0);
        lftIR_n = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("busy after abort", int'(busy), 0);
        checkOutput("lft_rail after abort", int'(lft_rail), 0);
        startMove(3'd0);
        checkOutput("busy on zero-square start", int'(busy), 0);
        repeat (4) @(negedge clk);

        // Three squares; abort lands on the sixth crossing's sample edge.
        startMove(3'd3);
        for (int k = 0; k < 21; k++) begin
            cntrIR_n = ((k % 4) < 2) ? 1'b0 : 1'b1;
            if ((k % 4) == 1) crossAtNext(1'b0);
            toStrobe();
        end
        cntrIR_n = 1'b0;
        while (cyc < nextStrobe - 1) @(negedge clk);
        abort = 1'b1;
        crossAtNext(1'b0);
        @(negedge clk);
        abort = 1'b0;
        nextStrobe += P;
        checkOutput("line_cnt at abort", int'(line_cnt), 6);
        checkOutput("busy after abort+cross", int'(busy), 0);
        checkOutput("IR_en after abort+cross", int'(IR_en), 0);
        cntrIR_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reset mid-move at line_cnt 3, then a fresh one-square move.
        startMove(3'd3);
        for (int k = 0; k < 10; k++) begin
            cntrIR_n = ((k % 4) < 2) ? 1'b0 : 1'b1;
            if ((k % 4) == 1) crossAtNext(1'b0);
            toStrobe();
        end
        cntrIR_n = 1'b1;
        rst = 1'b1;
        pushExp(LINE, 0, cyc + 1);
        expLine = 0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst IR_en", int'(IR_en), 0);
        checkOutput("rst line_cnt", int'(line_cnt), 0);
        checkOutput("rst rails", int'({lft_rail, rght_rail}), 0);
        startMove(3'd1);
        for (int k = 0; k < 6; k++) begin
            cntrIR_n = ((k % 4) < 2) ? 1'b0 : 1'b1;
            if (k == 1) crossAtNext(1'b0);
            if (k == 5) crossAtNext(1'b1);
            toStrobe();
        end
        checkOutput("busy after post-reset move", int'(busy), 0);
        cntrIR_n = 1'b1;
        repeat (4) @(negedge clk);

        // No crossings at all.
        startMove(3'd2);
`ifdef IR_TIMEOUT_EN
        pushExp(ERR, 0, nextStrobe + (TMO - 1) * P);
        for (int k = 0; k < TMO; k++) toStrobe();
        checkOutput("busy after timeout", int'(busy), 0);
`else
        for (int k = 0; k < TMO + 2; k++) toStrobe();
        checkOutput("busy without timeout", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("busy after final abort", int'(busy), 0);
`endif

        repeat (10) @(negedge clk);
        checkOutput("pending expected events", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
